// File: rtl/draw_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
// Shared definitions for the HUD draw path: BCD digit type, the code the
// sprite stage substitutes for blanked digits, and the converter FSM states.
// No ports (package).
// -----------------------------------------------------------------------------
package draw_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    // Substituted for a digit by the sprite stage when its BlankMask bit is set.
    localparam bcd_t BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } conv_state_e;

endpackage

// File: rtl/bcd_dabble_step.sv
// -----------------------------------------------------------------------------
// bcd_dabble_step
// One combinational double-dabble iteration on a {BCD, BIN} shift register:
// every BCD nibble >= 5 gets +3 (4-bit, no carry into the next nibble), then
// the whole register shifts left by one. The bit leaving the MSD is dropped.
// Ports:
//   sh_i  in   NUM_DIGIT*4+BIN_W   current shift register {BCD field, BIN field}
//   sh_o  out  NUM_DIGIT*4+BIN_W   register after add-3 and left shift
// -----------------------------------------------------------------------------
module bcd_dabble_step
    import draw_pkg::*;
#(
    parameter int NUM_DIGIT = 3,
    parameter int BIN_W     = 10
) (
    input  logic [NUM_DIGIT*DIGIT_W+BIN_W-1:0] sh_i,
    output logic [NUM_DIGIT*DIGIT_W+BIN_W-1:0] sh_o
);

    logic [NUM_DIGIT*DIGIT_W+BIN_W-1:0] adj;

    always_comb begin
        adj = sh_i;
        for (int k = 0; k < NUM_DIGIT; k++) begin
            if (sh_i[BIN_W + k*DIGIT_W +: DIGIT_W] >= 4'd5) begin
                adj[BIN_W + k*DIGIT_W +: DIGIT_W] = sh_i[BIN_W + k*DIGIT_W +: DIGIT_W] + 4'd3;
            end
        end
        sh_o = adj << 1;
    end

endmodule

// File: rtl/stat_bcd_converter.sv
// -----------------------------------------------------------------------------
// stat_bcd_converter
// Sequential binary-to-BCD converter for HUD stat values. One conversion per
// Start request; results are registered and held until the next conversion
// completes, so the downstream sprite stage sees stable digits all frame.
// Ports:
//   Clk        in   1              system clock
//   Reset      in   1              synchronous active-high reset
//   Start      in   1              conversion request (level sampled)
//   Value      in   BIN_W          binary value, sampled at the load edge
//   Digits     out  NUM_DIGIT x 4  BCD digits, [NUM_DIGIT-1] is the MSD
//   BlankMask  out  NUM_DIGIT      1 = leading zero digit; bit 0 always 0
//   Overflow   out  1              last converted Value exceeded 10**NUM_DIGIT-1
//   Valid      out  1              one-cycle pulse when results update
//   Busy       out  1              conversion in flight
// -----------------------------------------------------------------------------
module stat_bcd_converter
    import draw_pkg::*;
#(
    parameter int NUM_DIGIT = 3,
    parameter int BIN_W     = $clog2(10**NUM_DIGIT)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [BIN_W-1:0]     Value,
    output bcd_t [NUM_DIGIT-1:0] Digits,
    output logic [NUM_DIGIT-1:0] BlankMask,
    output logic                 Overflow,
    output logic                 Valid,
    output logic                 Busy
);

    localparam int          BCD_W   = NUM_DIGIT * DIGIT_W;
    localparam int          SH_W    = BCD_W + BIN_W;
    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam int unsigned MAX_VAL = 10**NUM_DIGIT - 1;
    localparam logic [NUM_DIGIT-1:0] MASK_RST = {{(NUM_DIGIT-1){1'b1}}, 1'b0};

    typedef bcd_t [NUM_DIGIT-1:0] digits_t;

    // Out-of-range values report all 9s rather than a truncated conversion.
    function automatic digits_t saturate(input digits_t raw, input logic ovf);
        digits_t res;
        res = raw;
        if (ovf) begin
            for (int k = 0; k < NUM_DIGIT; k++) begin
                res[k] = 4'd9;
            end
        end
        return res;
    endfunction

    // Bit k set when digit k and every more significant digit are zero; the
    // units digit is always drawn so a value of 0 still shows "0".
    function automatic logic [NUM_DIGIT-1:0] blank_mask(input digits_t d);
        logic [NUM_DIGIT-1:0] m;
        logic                 all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int k = NUM_DIGIT - 1; k >= 1; k--) begin
            all_zero = all_zero && (d[k] == 4'd0);
            m[k]     = all_zero;
        end
        return m;
    endfunction

    conv_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SH_W-1:0]      sh_q, sh_d, sh_step;
    logic                 ovf_cur_q, ovf_cur_d;
    logic                 pend_q, pend_d;
    digits_t              digits_q, digits_d;
    logic [NUM_DIGIT-1:0] mask_q, mask_d;
    logic                 ovf_q, ovf_d;
    logic                 valid_q, valid_d;
    logic                 load;
    digits_t              result;

    bcd_dabble_step #(
        .NUM_DIGIT (NUM_DIGIT),
        .BIN_W     (BIN_W)
    ) u_step (
        .sh_i (sh_q),
        .sh_o (sh_step)
    );

    assign result = saturate(sh_q[SH_W-1 -: BCD_W], ovf_cur_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        ovf_cur_d = ovf_cur_q;
        pend_d    = pend_q;
        digits_d  = digits_q;
        mask_d    = mask_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        load      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A Start that arrived during DONE is still served from here.
                if (Start || pend_q) begin
                    load   = 1'b1;
                    pend_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (Start) begin
                    pend_d = 1'b1;
                end
                sh_d  = sh_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                valid_d  = 1'b1;
                digits_d = result;
                mask_d   = blank_mask(result);
                ovf_d    = ovf_cur_q;
                if (pend_q) begin
                    // The queued request samples Value now, at its own load edge.
                    load   = 1'b1;
                    pend_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    pend_d  = Start;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            state_d   = ST_SHIFT;
            sh_d      = {{BCD_W{1'b0}}, Value};
            cnt_d     = CNT_W'(BIN_W);
            ovf_cur_d = (32'(Value) > MAX_VAL);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            ovf_cur_q <= 1'b0;
            pend_q    <= 1'b0;
            digits_q  <= '0;
            mask_q    <= MASK_RST;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            ovf_cur_q <= ovf_cur_d;
            pend_q    <= pend_d;
            digits_q  <= digits_d;
            mask_q    <= mask_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign Digits    = digits_q;
    assign BlankMask = mask_q;
    assign Overflow  = ovf_q;
    assign Valid     = valid_q;
    assign Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_stat_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_stat_bcd_converter
// Directed bench for stat_bcd_converter (NUM_DIGIT=3, BIN_W=10): reset values,
// latency, digit/mask/overflow results, pending-request collapse, abort by
// reset, and a full 0..1023 sweep against a decimal reference.
// -----------------------------------------------------------------------------
module tb_stat_bcd_converter;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [9:0]  Value;
    logic [11:0] Digits;
    logic [2:0]  BlankMask;
    logic        Overflow;
    logic        Valid;
    logic        Busy;

    int n_cmp = 0;
    int n_err = 0;

    stat_bcd_converter #(
        .NUM_DIGIT (3),
        .BIN_W     (10)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Value     (Value),
        .Digits    (Digits),
        .BlankMask (BlankMask),
        .Overflow  (Overflow),
        .Valid     (Valid),
        .Busy      (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, mask[2:0], digits[11:0]} from plain decimal arithmetic.
    function automatic logic [15:0] model(input int v);
        int         h, t, u;
        logic       ovf;
        logic [2:0] m;
        logic [11:0] dg;
        if (v > 999) begin
            h = 9; t = 9; u = 9; ovf = 1'b1;
        end else begin
            h = (v / 100) % 10; t = (v / 10) % 10; u = v % 10; ovf = 1'b0;
        end
        m[2] = (h == 0);
        m[1] = (h == 0) && (t == 0);
        m[0] = 1'b0;
        dg = {h[3:0], t[3:0], u[3:0]};
        return {ovf, m, dg};
    endfunction

    // One request from idle: result must appear exactly 11 cycles after the
    // accepting edge, with no Valid or digit change before that.
    task automatic run_conv(input string tag, input logic [9:0] v,
                            input logic [11:0] ed, input logic [2:0] em, input logic eo);
        logic [11:0] prev;
        int          early;
        prev  = Digits;
        early = 0;
        Start = 1'b1;
        Value = v;
        tick();
        Start = 1'b0;
        check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
        if (Valid !== 1'b0 || Digits !== prev) early++;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (Valid !== 1'b0 || Digits !== prev) early++;
        end
        check({tag, "_early"}, early, 0);
        tick();
        check({tag, "_valid"}, {31'd0, Valid}, 32'd1);
        check({tag, "_digits"}, {20'd0, Digits}, {20'd0, ed});
        check({tag, "_mask"}, {29'd0, BlankMask}, {29'd0, em});
        check({tag, "_ovf"}, {31'd0, Overflow}, {31'd0, eo});
        check({tag, "_idle"}, {31'd0, Busy}, 32'd0);
        tick();
        check({tag, "_pulse"}, {31'd0, Valid}, 32'd0);
    endtask

    int          c, npulse, t1, t2, bad;
    logic [11:0] dg1, dg2;
    logic [2:0]  m2;
    logic [15:0] ref_v;

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Value = '0;
        tick();
        tick();
        Reset = 1'b0;
        check("rst_digits", {20'd0, Digits}, 32'h000);
        check("rst_mask", {29'd0, BlankMask}, 32'b110);
        check("rst_ovf", {31'd0, Overflow}, 32'd0);
        check("rst_valid", {31'd0, Valid}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);

        run_conv("v305", 10'd305, 12'h305, 3'b000, 1'b0);
        run_conv("v0", 10'd0, 12'h000, 3'b110, 1'b0);
        run_conv("v40", 10'd40, 12'h040, 3'b100, 1'b0);
        run_conv("v7", 10'd7, 12'h007, 3'b110, 1'b0);
        run_conv("v999", 10'd999, 12'h999, 3'b000, 1'b0);
        run_conv("v1023", 10'd1023, 12'h999, 3'b000, 1'b1);
        run_conv("v12", 10'd12, 12'h012, 3'b100, 1'b0);

        // Start held for three edges, then a second Start mid-conversion with
        // a new Value: exactly one extra conversion, using Value 88.
        Start = 1'b1;
        Value = 10'd123;
        tick();
        tick();
        tick();
        Start = 1'b0;
        Value = 10'd88;
        tick();
        tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        c = 5; npulse = 0; t1 = -1; t2 = -1; dg1 = '0; dg2 = '0; m2 = '0;
        while (c < 40) begin
            tick();
            c++;
            if (Valid === 1'b1) begin
                npulse++;
                if (npulse == 1) begin
                    t1 = c; dg1 = Digits;
                end else if (npulse == 2) begin
                    t2 = c; dg2 = Digits; m2 = BlankMask;
                end
            end
        end
        check("pend_pulses", npulse, 2);
        check("pend_t1", t1, 11);
        check("pend_dig1", {20'd0, dg1}, 32'h123);
        check("pend_t2", t2, 22);
        check("pend_dig2", {20'd0, dg2}, 32'h088);
        check("pend_mask2", {29'd0, m2}, 32'b100);
        check("pend_idle", {31'd0, Busy}, 32'd0);

        // Reset five edges into a conversion of 777 discards it.
        Start = 1'b1;
        Value = 10'd777;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort_digits", {20'd0, Digits}, 32'h000);
        check("abort_mask", {29'd0, BlankMask}, 32'b110);
        check("abort_ovf", {31'd0, Overflow}, 32'd0);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Valid !== 1'b0 || Digits !== 12'h000 || Busy !== 1'b0) bad++;
        end
        check("abort_quiet", bad, 0);

        // Reset and Start together: Reset wins.
        Reset = 1'b1;
        Start = 1'b1;
        Value = 10'd5;
        tick();
        check("rst_start_busy", {31'd0, Busy}, 32'd0);
        Reset = 1'b0;
        Start = 1'b0;
        tick();
        check("rst_start_idle", {31'd0, Busy}, 32'd0);
        check("rst_start_valid", {31'd0, Valid}, 32'd0);

        for (int v = 0; v < 1024; v++) begin
            ref_v = model(v);
            run_conv($sformatf("sweep%0d", v), v[9:0], ref_v[11:0], ref_v[14:12], ref_v[15]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
